even_issue_ctrl: RTL and testbench

Issue stage directly upstream of the even execution pipe. It accepts one decoded even-pipe instruction per cycle from decode over a valid/ready handshake and holds it in an issue register that drives the pipe's stage-1 inputs. It tracks every in-flight even-pipe writer in a 7-entry shadow scoreboard that mirrors pipe stages 1–7, including the pipe's flush behaviour. It stalls any instruction whose source register cannot yet be forwarded, and inserts an even NOP bubble in its place.

---
 rtl/even_issue_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_even_issue_ctrl.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/even_issue_ctrl.sv
// even_issue_ctrl
// Issue stage in front of the even execution pipe. It takes one decoded
// instruction per cycle from decode (valid/ready) into an issue register that
// drives pipe stage 1. A 7-entry shadow scoreboard follows every in-flight
// register writer through stages 1..7 and copies the pipe's flush behaviour.
// A candidate whose source cannot be forwarded yet is held, and an even NOP
// bubble goes down the pipe in its place.
//
// Optional feature: define EVEN_ISSUE_STATS_EN to add the issue, stall and
// flush event counters (issue_count, stall_count, flush_count).

module even_issue_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        flush_4stage,

  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  in_instr_id,
  input  logic [2:0]  in_unit_id,
  input  logic [3:0]  in_latency,
  input  logic        in_reg_wr,
  input  logic [6:0]  in_reg_dst,
  input  logic [6:0]  in_ra_addr,
  input  logic [6:0]  in_rb_addr,
  input  logic [6:0]  in_rc_addr,
  input  logic        in_ra_use,
  input  logic        in_rb_use,
  input  logic        in_rc_use,
  input  logic [6:0]  in_imme7,
  input  logic [9:0]  in_imme10,
  input  logic [15:0] in_imme16,
  input  logic [17:0] in_imme18,

  output logic [6:0]  out_instr_id,
  output logic [2:0]  out_unit_id,
  output logic [3:0]  out_latency,
  output logic        out_reg_wr,
  output logic [6:0]  out_reg_dst,
  output logic [6:0]  out_ra_addr,
  output logic [6:0]  out_rb_addr,
  output logic [6:0]  out_rc_addr,
  output logic [6:0]  out_imme7,
  output logic [9:0]  out_imme10,
  output logic [15:0] out_imme16,
  output logic [17:0] out_imme18,

  output logic        stall
`ifdef EVEN_ISSUE_STATS_EN
  ,
  output logic [31:0] issue_count,
  output logic [31:0] stall_count,
  output logic [15:0] flush_count
`endif
);

  // Opcode id of the even-pipe NOP used as the bubble
  localparam logic [6:0] NOP_ID = 7'd86;
  localparam int         DEPTH  = 7;

  // Shadow scoreboard: entry k describes the writer in pipe stage k
  logic [DEPTH:1] sb_valid;
  logic [6:0]     sb_dst [1:DEPTH];
  logic [3:0]     sb_lat [1:DEPTH];

  // Entry k is still too young to be forwarded to a new stage-1 consumer
  logic [DEPTH:1] too_early;

  // Per-source, per-entry hazard hits
  logic [DEPTH:1] ra_hit;
  logic [DEPTH:1] rb_hit;
  logic [DEPTH:1] rc_hit;

  logic hazard;
  logic accept;

  // Next value of the issue register (either the candidate or a bubble)
  logic [6:0]  nxt_instr_id;
  logic [2:0]  nxt_unit_id;
  logic [3:0]  nxt_latency;
  logic        nxt_reg_wr;
  logic [6:0]  nxt_reg_dst;
  logic [6:0]  nxt_ra_addr;
  logic [6:0]  nxt_rb_addr;
  logic [6:0]  nxt_rc_addr;
  logic [6:0]  nxt_imme7;
  logic [9:0]  nxt_imme10;
  logic [15:0] nxt_imme16;
  logic [17:0] nxt_imme18;

  // Next value of scoreboard entry 1
  logic        nxt_sb1_valid;
  logic [6:0]  nxt_sb1_dst;
  logic [3:0]  nxt_sb1_lat;

  // A producer in stage k with latency L can feed a consumer only when k+1 >= L
  always_comb begin
    too_early = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      too_early[k] = sb_valid[k] && (4'(k + 1) < sb_lat[k]);
    end
  end

  // Match each used source against every entry; each match is judged on its own
  always_comb begin
    ra_hit = '0;
    rb_hit = '0;
    rc_hit = '0;
    for (int k = 1; k <= DEPTH; k++) begin
      ra_hit[k] = too_early[k] && in_ra_use && (sb_dst[k] == in_ra_addr);
      rb_hit[k] = too_early[k] && in_rb_use && (sb_dst[k] == in_rb_addr);
      rc_hit[k] = too_early[k] && in_rc_use && (sb_dst[k] == in_rc_addr);
    end
  end

  assign hazard   = (|ra_hit) | (|rb_hit) | (|rc_hit);
  assign in_ready = ~rst & ~flush & ~hazard;
  assign stall    = in_valid & hazard & ~flush & ~rst;
  assign accept   = in_valid & in_ready;

  // Pick what enters stage 1: the accepted instruction or an all-zero NOP bubble
  always_comb begin
    nxt_instr_id  = NOP_ID;
    nxt_unit_id   = 3'd0;
    nxt_latency   = 4'd0;
    nxt_reg_wr    = 1'b0;
    nxt_reg_dst   = 7'd0;
    nxt_ra_addr   = 7'd0;
    nxt_rb_addr   = 7'd0;
    nxt_rc_addr   = 7'd0;
    nxt_imme7     = 7'd0;
    nxt_imme10    = 10'd0;
    nxt_imme16    = 16'd0;
    nxt_imme18    = 18'd0;
    nxt_sb1_valid = 1'b0;
    nxt_sb1_dst   = 7'd0;
    nxt_sb1_lat   = 4'd0;
    if (accept) begin
      nxt_instr_id  = in_instr_id;
      nxt_unit_id   = in_unit_id;
      nxt_latency   = in_latency;
      nxt_reg_wr    = in_reg_wr;
      nxt_reg_dst   = in_reg_dst;
      nxt_ra_addr   = in_ra_addr;
      nxt_rb_addr   = in_rb_addr;
      nxt_rc_addr   = in_rc_addr;
      nxt_imme7     = in_imme7;
      nxt_imme10    = in_imme10;
      nxt_imme16    = in_imme16;
      nxt_imme18    = in_imme18;
      nxt_sb1_valid = in_reg_wr && (in_instr_id != NOP_ID);
      nxt_sb1_dst   = in_reg_dst;
      nxt_sb1_lat   = in_latency;
    end
  end

  // Issue register feeding the even pipe's stage-1 inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_instr_id <= NOP_ID;
      out_unit_id  <= 3'd0;
      out_latency  <= 4'd0;
      out_reg_wr   <= 1'b0;
      out_reg_dst  <= 7'd0;
      out_ra_addr  <= 7'd0;
      out_rb_addr  <= 7'd0;
      out_rc_addr  <= 7'd0;
      out_imme7    <= 7'd0;
      out_imme10   <= 10'd0;
      out_imme16   <= 16'd0;
      out_imme18   <= 18'd0;
    end else begin
      out_instr_id <= nxt_instr_id;
      out_unit_id  <= nxt_unit_id;
      out_latency  <= nxt_latency;
      out_reg_wr   <= nxt_reg_wr;
      out_reg_dst  <= nxt_reg_dst;
      out_ra_addr  <= nxt_ra_addr;
      out_rb_addr  <= nxt_rb_addr;
      out_rc_addr  <= nxt_rc_addr;
      out_imme7    <= nxt_imme7;
      out_imme10   <= nxt_imme10;
      out_imme16   <= nxt_imme16;
      out_imme18   <= nxt_imme18;
    end
  end

  // Scoreboard advances with the pipe; a flush kills stages 1-3 (and 4 if asked)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sb_valid <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        sb_dst[k] <= 7'd0;
        sb_lat[k] <= 4'd0;
      end
    end else begin
      sb_valid[1] <= nxt_sb1_valid;
      sb_dst[1]   <= nxt_sb1_dst;
      sb_lat[1]   <= nxt_sb1_lat;
      for (int k = 2; k <= DEPTH; k++) begin
        sb_valid[k] <= sb_valid[k-1];
        sb_dst[k]   <= sb_dst[k-1];
        sb_lat[k]   <= sb_lat[k-1];
      end
      if (flush) begin
        sb_valid[2] <= 1'b0;
        sb_valid[3] <= 1'b0;
        if (flush_4stage) begin
          sb_valid[4] <= 1'b0;
        end
      end
    end
  end

`ifdef EVEN_ISSUE_STATS_EN
  // Free-running event counters that wrap on overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_count <= 32'd0;
      stall_count <= 32'd0;
      flush_count <= 16'd0;
    end else begin
      if (accept) begin
        issue_count <= issue_count + 32'd1;
      end
      if (stall) begin
        stall_count <= stall_count + 32'd1;
      end
      if (flush) begin
        flush_count <= flush_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_even_issue_ctrl.sv
// tb_even_issue_ctrl
// Directed, table-driven bench for even_issue_ctrl: each table row is one
// cycle of decode/flush inputs with the hand-computed in_ready, stall and the
// instruction expected in the issue register after the following edge.
// A hand-written sequence covers reset asserted in the middle of a stall.

module tb_even_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        flush_4stage;
  logic        in_valid;
  logic        in_ready;
  logic [6:0]  in_instr_id;
  logic [2:0]  in_unit_id;
  logic [3:0]  in_latency;
  logic        in_reg_wr;
  logic [6:0]  in_reg_dst;
  logic [6:0]  in_ra_addr;
  logic [6:0]  in_rb_addr;
  logic [6:0]  in_rc_addr;
  logic        in_ra_use;
  logic        in_rb_use;
  logic        in_rc_use;
  logic [6:0]  in_imme7;
  logic [9:0]  in_imme10;
  logic [15:0] in_imme16;
  logic [17:0] in_imme18;
  logic [6:0]  out_instr_id;
  logic [2:0]  out_unit_id;
  logic [3:0]  out_latency;
  logic        out_reg_wr;
  logic [6:0]  out_reg_dst;
  logic [6:0]  out_ra_addr;
  logic [6:0]  out_rb_addr;
  logic [6:0]  out_rc_addr;
  logic [6:0]  out_imme7;
  logic [9:0]  out_imme10;
  logic [15:0] out_imme16;
  logic [17:0] out_imme18;
  logic        stall;
`ifdef EVEN_ISSUE_STATS_EN
  logic [31:0] issue_count;
  logic [31:0] stall_count;
  logic [15:0] flush_count;
`endif

  even_issue_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .flush_4stage (flush_4stage),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_instr_id  (in_instr_id),
    .in_unit_id   (in_unit_id),
    .in_latency   (in_latency),
    .in_reg_wr    (in_reg_wr),
    .in_reg_dst   (in_reg_dst),
    .in_ra_addr   (in_ra_addr),
    .in_rb_addr   (in_rb_addr),
    .in_rc_addr   (in_rc_addr),
    .in_ra_use    (in_ra_use),
    .in_rb_use    (in_rb_use),
    .in_rc_use    (in_rc_use),
    .in_imme7     (in_imme7),
    .in_imme10    (in_imme10),
    .in_imme16    (in_imme16),
    .in_imme18    (in_imme18),
    .out_instr_id (out_instr_id),
    .out_unit_id  (out_unit_id),
    .out_latency  (out_latency),
    .out_reg_wr   (out_reg_wr),
    .out_reg_dst  (out_reg_dst),
    .out_ra_addr  (out_ra_addr),
    .out_rb_addr  (out_rb_addr),
    .out_rc_addr  (out_rc_addr),
    .out_imme7    (out_imme7),
    .out_imme10   (out_imme10),
    .out_imme16   (out_imme16),
    .out_imme18   (out_imme18),
    .stall        (stall)
`ifdef EVEN_ISSUE_STATS_EN
    ,
    .issue_count  (issue_count),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       valid;
    logic       flush;
    logic       f4;
    logic [6:0] id;
    logic       wr;
    logic [6:0] dst;
    logic [3:0] lat;
    logic [6:0] ra;
    logic       rau;
    logic [6:0] rb;
    logic       rbu;
    logic [6:0] rc;
    logic       rcu;
    logic       exp_ready;
    logic       exp_stall;
    logic [6:0] exp_id;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input string name, input logic valid, input logic fl, input logic f4,
                              input logic [6:0] id, input logic wr, input logic [6:0] dst,
                              input logic [3:0] lat, input logic [6:0] ra, input logic rau,
                              input logic [6:0] rb, input logic rbu, input logic [6:0] rc,
                              input logic rcu, input logic rdy, input logic stl,
                              input logic [6:0] oid);
    vec_t v;
    v.name = name; v.valid = valid; v.flush = fl; v.f4 = f4;
    v.id = id; v.wr = wr; v.dst = dst; v.lat = lat;
    v.ra = ra; v.rau = rau; v.rb = rb; v.rbu = rbu; v.rc = rc; v.rcu = rcu;
    v.exp_ready = rdy; v.exp_stall = stl; v.exp_id = oid;
    return v;
  endfunction

  function automatic vec_t idle(input string name);
    return mk(name, 0, 0, 0, 7'd0, 0, 7'd0, 4'd0, 7'd0, 0, 7'd0, 0, 7'd0, 0, 1, 0, 7'd86);
  endfunction

  function automatic vec_t prod(input string name, input logic [6:0] id, input logic [6:0] dst,
                                input logic [3:0] lat);
    return mk(name, 1, 0, 0, id, 1, dst, lat, 7'd0, 0, 7'd0, 0, 7'd0, 0, 1, 0, id);
  endfunction

  function automatic vec_t cons(input string name, input logic [6:0] id,
                                input logic [6:0] ra, input logic rau, input logic [6:0] rb,
                                input logic rbu, input logic [6:0] rc, input logic rcu,
                                input logic fl, input logic f4, input logic rdy, input logic stl,
                                input logic [6:0] oid);
    return mk(name, 1, fl, f4, id, 0, 7'd0, 4'd1, ra, rau, rb, rbu, rc, rcu, rdy, stl, oid);
  endfunction

  function automatic logic [2:0] unit_of(input logic [6:0] id);
    return 3'(id[1:0]) + 3'd1;
  endfunction

  // Registered fields other than instr_id that an accepted row must produce
  function automatic logic [127:0] exp_rest(input vec_t v);
    logic [127:0] r;
    r = '0;
    if (v.valid && v.exp_ready) begin
      r = 128'({unit_of(v.id), v.lat, v.wr, v.dst, v.ra, v.rb, v.rc,
                v.id ^ 7'h2a, {3'b101, v.id}, {v.id, 9'h1a5}, {11'h3c3, v.id}});
    end
    return r;
  endfunction

  function automatic logic [127:0] act_rest();
    return 128'({out_unit_id, out_latency, out_reg_wr, out_reg_dst, out_ra_addr, out_rb_addr,
                 out_rc_addr, out_imme7, out_imme10, out_imme16, out_imme18});
  endfunction

  task automatic applyStimulus(input vec_t v);
    in_valid     = v.valid;
    flush        = v.flush;
    flush_4stage = v.f4;
    in_instr_id  = v.id;
    in_unit_id   = unit_of(v.id);
    in_latency   = v.lat;
    in_reg_wr    = v.wr;
    in_reg_dst   = v.dst;
    in_ra_addr   = v.ra;
    in_rb_addr   = v.rb;
    in_rc_addr   = v.rc;
    in_ra_use    = v.rau;
    in_rb_use    = v.rbu;
    in_rc_use    = v.rcu;
    in_imme7     = v.id ^ 7'h2a;
    in_imme10    = {3'b101, v.id};
    in_imme16    = {v.id, 9'h1a5};
    in_imme18    = {11'h3c3, v.id};
  endtask

  task automatic checkOutput(input string name, input logic [127:0] actual,
                             input logic [127:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired before the end of the test");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int exp_issue = 0;
    int exp_stalls = 0;
    int exp_flushes = 0;
    vec_t held;

    // Scenario table, one row per cycle, starting right after reset
    vecs.push_back(idle("idle0"));
    // r5, L=6: consumer arrives with producer in stage 2 -> 3 stalls
    vecs.push_back(prod("A_prod", 7'd10, 7'd5, 4'd6));
    vecs.push_back(idle("A_gap"));
    vecs.push_back(cons("A_st1", 7'd11, 7'd5, 1, 7'd0, 0, 7'd0, 0, 0, 0, 0, 1, 7'd86));
    vecs.push_back(cons("A_st2", 7'd11, 7'd5, 1, 7'd0, 0, 7'd0, 0, 0, 0, 0, 1, 7'd86));
    vecs.push_back(cons("A_st3", 7'd11, 7'd5, 1, 7'd0, 0, 7'd0, 0, 0, 0, 0, 1, 7'd86));
    vecs.push_back(cons("A_iss", 7'd11, 7'd5, 1, 7'd0, 0, 7'd0, 0, 0, 0, 1, 0, 7'd11));
    // r9, L=2: back-to-back
    vecs.push_back(prod("B_prod", 7'd12, 7'd9, 4'd2));
    vecs.push_back(cons("B_cons", 7'd13, 7'd9, 1, 7'd0, 0, 7'd0, 0, 0, 0, 1, 0, 7'd13));
    vecs.push_back(idle("B_idle"));
    // r7, L=7 flushed out of stage 2; flush also blocks the waiting consumer
    vecs.push_back(prod("C_prod", 7'd14, 7'd7, 4'd7));
    vecs.push_back(idle("C_gap"));
    vecs.push_back(cons("C_flush", 7'd15, 7'd7, 1, 7'd0, 0, 7'd0, 0, 1, 0, 0, 0, 7'd86));
    vecs.push_back(cons("C_cons", 7'd15, 7'd7, 1, 7'd0, 0, 7'd0, 0, 0, 0, 1, 0, 7'd15));
    // r3, L=7 in stage 3 at flush, flush_4stage=0: survives into stage 4
    vecs.push_back(prod("D_prod", 7'd16, 7'd3, 4'd7));
    vecs.push_back(idle("D_gap1"));
    vecs.push_back(idle("D_gap2"));
    vecs.push_back(cons("D_flush", 7'd17, 7'd0, 0, 7'd3, 1, 7'd0, 0, 1, 0, 0, 0, 7'd86));
    vecs.push_back(cons("D_st1", 7'd17, 7'd0, 0, 7'd3, 1, 7'd0, 0, 0, 0, 0, 1, 7'd86));
    vecs.push_back(cons("D_st2", 7'd17, 7'd0, 0, 7'd3, 1, 7'd0, 0, 0, 0, 0, 1, 7'd86));
    vecs.push_back(cons("D_iss", 7'd17, 7'd0, 0, 7'd3, 1, 7'd0, 0, 0, 0, 1, 0, 7'd17));
    // same with flush_4stage=1: producer removed
    vecs.push_back(prod("D2_prod", 7'd18, 7'd3, 4'd7));
    vecs.push_back(idle("D2_gap1"));
    vecs.push_back(idle("D2_gap2"));
    vecs.push_back(mk("D2_flush", 0, 1, 1, 7'd0, 0, 7'd0, 4'd0, 7'd0, 0, 7'd0, 0, 7'd0, 0,
                      0, 0, 7'd86));
    vecs.push_back(cons("D2_cons", 7'd19, 7'd3, 1, 7'd0, 0, 7'd0, 0, 0, 0, 1, 0, 7'd19));
    // flush holds off an independent instruction
    vecs.push_back(cons("F_flush", 7'd20, 7'd30, 1, 7'd0, 0, 7'd0, 0, 1, 0, 0, 0, 7'd86));
    vecs.push_back(cons("F_iss", 7'd20, 7'd30, 1, 7'd0, 0, 7'd0, 0, 0, 0, 1, 0, 7'd20));
    // r10, L=5: unused rb never stalls, used rb stalls 2 cycles
    vecs.push_back(prod("E_prod", 7'd21, 7'd10, 4'd5));
    vecs.push_back(idle("E_gap"));
    vecs.push_back(cons("E_nouse", 7'd22, 7'd0, 0, 7'd10, 0, 7'd0, 0, 0, 0, 1, 0, 7'd22));
    vecs.push_back(prod("E_prod2", 7'd23, 7'd10, 4'd5));
    vecs.push_back(idle("E_gap2"));
    vecs.push_back(cons("E_st1", 7'd24, 7'd0, 0, 7'd10, 1, 7'd0, 0, 0, 0, 0, 1, 7'd86));
    vecs.push_back(cons("E_st2", 7'd24, 7'd0, 0, 7'd10, 1, 7'd0, 0, 0, 0, 0, 1, 7'd86));
    vecs.push_back(cons("E_iss", 7'd24, 7'd0, 0, 7'd10, 1, 7'd0, 0, 0, 0, 1, 0, 7'd24));
    // r12 in two entries: young L=2 copy is fine, older L=5 copy still blocks (via rc)
    vecs.push_back(prod("M_prodA", 7'd25, 7'd12, 4'd5));
    vecs.push_back(prod("M_prodB", 7'd26, 7'd12, 4'd2));
    vecs.push_back(cons("M_st1", 7'd27, 7'd0, 0, 7'd0, 0, 7'd12, 1, 0, 0, 0, 1, 7'd86));
    vecs.push_back(cons("M_st2", 7'd27, 7'd0, 0, 7'd0, 0, 7'd12, 1, 0, 0, 0, 1, 7'd86));
    vecs.push_back(cons("M_iss", 7'd27, 7'd0, 0, 7'd0, 0, 7'd12, 1, 0, 0, 1, 0, 7'd27));
    // a NOP with reg_wr=1 and a reg_wr=0 instruction are not tracked
    vecs.push_back(mk("N_nop", 1, 0, 0, 7'd86, 1, 7'd13, 4'd7, 7'd0, 0, 7'd0, 0, 7'd0, 0,
                      1, 0, 7'd86));
    vecs.push_back(cons("N_cons", 7'd28, 7'd13, 1, 7'd0, 0, 7'd0, 0, 0, 0, 1, 0, 7'd28));
    vecs.push_back(mk("W_prod", 1, 0, 0, 7'd29, 0, 7'd14, 4'd7, 7'd0, 0, 7'd0, 0, 7'd0, 0,
                      1, 0, 7'd29));
    vecs.push_back(cons("W_cons", 7'd30, 7'd14, 1, 7'd0, 0, 7'd0, 0, 0, 0, 1, 0, 7'd30));
    // L=3 boundary: stalls only while the producer is in stage 1
    vecs.push_back(prod("L3_prod", 7'd31, 7'd16, 4'd3));
    vecs.push_back(cons("L3_st", 7'd32, 7'd16, 1, 7'd0, 0, 7'd0, 0, 0, 0, 0, 1, 7'd86));
    vecs.push_back(cons("L3_iss", 7'd32, 7'd16, 1, 7'd0, 0, 7'd0, 0, 0, 0, 1, 0, 7'd32));
    vecs.push_back(idle("end_idle"));

    // Reset: combinational outputs forced low, issue register holds the bubble
    rst = 1'b1;
    applyStimulus(cons("rst_in", 7'd40, 7'd5, 1, 7'd0, 0, 7'd0, 0, 0, 0, 0, 0, 7'd86));
    #2;
    checkOutput("rst_ready", 128'(in_ready), 128'(1'b0));
    checkOutput("rst_stall", 128'(stall), 128'(1'b0));
    checkOutput("rst_out_id", 128'(out_instr_id), 128'(7'd86));
    checkOutput("rst_out_rest", act_rest(), 128'd0);
    @(posedge clk);
    @(posedge clk);
    #2;
    applyStimulus(idle("release"));
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      #2;
      checkOutput({vecs[i].name, "/in_ready"}, 128'(in_ready), 128'(vecs[i].exp_ready));
      checkOutput({vecs[i].name, "/stall"}, 128'(stall), 128'(vecs[i].exp_stall));
      @(posedge clk);
      #1;
      checkOutput({vecs[i].name, "/out_id"}, 128'(out_instr_id), 128'(vecs[i].exp_id));
      checkOutput({vecs[i].name, "/out_rest"}, act_rest(), exp_rest(vecs[i]));
      if (vecs[i].valid && vecs[i].exp_ready) exp_issue++;
      if (vecs[i].exp_stall) exp_stalls++;
      if (vecs[i].flush) exp_flushes++;
    end

`ifdef EVEN_ISSUE_STATS_EN
    checkOutput("issue_count", 128'(issue_count), 128'(exp_issue));
    checkOutput("stall_count", 128'(stall_count), 128'(exp_stalls));
    checkOutput("flush_count", 128'(flush_count), 128'(exp_flushes));
`endif

    // Reset asserted mid-stall clears everything at once; held consumer then issues
    applyStimulus(prod("R_prod", 7'd33, 7'd15, 4'd7));
    @(posedge clk);
    #1;
    checkOutput("R_prod/out_id", 128'(out_instr_id), 128'(7'd33));
    held = cons("R_cons", 7'd34, 7'd15, 1, 7'd0, 0, 7'd0, 0, 0, 0, 1, 0, 7'd34);
    applyStimulus(held);
    #1;
    checkOutput("R_pre/stall", 128'(stall), 128'(1'b1));
    checkOutput("R_pre/in_ready", 128'(in_ready), 128'(1'b0));
    #1 rst = 1'b1;
    #1;
    checkOutput("R_async/out_id", 128'(out_instr_id), 128'(7'd86));
    checkOutput("R_async/out_rest", act_rest(), 128'd0);
    checkOutput("R_async/stall", 128'(stall), 128'(1'b0));
    checkOutput("R_async/in_ready", 128'(in_ready), 128'(1'b0));
    @(posedge clk);
    #2 rst = 1'b0;
    #2;
    checkOutput("R_post/in_ready", 128'(in_ready), 128'(1'b1));
    checkOutput("R_post/stall", 128'(stall), 128'(1'b0));
    @(posedge clk);
    #1;
    checkOutput("R_post/out_id", 128'(out_instr_id), 128'(7'd34));
    checkOutput("R_post/out_rest", act_rest(), exp_rest(held));
`ifdef EVEN_ISSUE_STATS_EN
    checkOutput("R_post/issue_count", 128'(issue_count), 128'(32'd1));
    checkOutput("R_post/stall_count", 128'(stall_count), 128'(32'd0));
`endif
    applyStimulus(idle("done"));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
